// File: rtl/pair_word_packer_pkg.sv
// Shared constants, FSM state type and width helper for the pair-to-word packer.
package pair_word_packer_pkg;

  localparam int PAIR_W     = 2;
  localparam int WORD_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    STALL   = 2'd2
  } pack_state_e;

  // fill_cnt width: enough to count PAIRS-1 plus one spare bit for headroom.
  function automatic int fill_w(input int word_w);
    return $clog2(word_w / PAIR_W) + 1;
  endfunction

endpackage

// File: rtl/pair_word_packer_if.sv
// Pair-in / word-out handshake bundle; master is the upstream+downstream side, slave the packer.
interface pair_word_packer_if #(
  parameter int WORD_W = 8
);
  import pair_word_packer_pkg::*;

  localparam int FILL_W = fill_w(WORD_W);

  logic [PAIR_W-1:0]     pair_in;
  logic                  pair_valid;
  logic                  pair_ready;
  logic                  flush;
  logic [WORD_W-1:0]     word_out;
  logic                  word_valid;
  logic                  word_ready;
  logic [FILL_W-1:0]     fill_cnt;
  logic [WORD_CNT_W-1:0] word_cnt;

  modport master (
    output pair_in, pair_valid, flush, word_ready,
    input  pair_ready, word_out, word_valid, fill_cnt, word_cnt
  );

  modport slave (
    input  pair_in, pair_valid, flush, word_ready,
    output pair_ready, word_out, word_valid, fill_cnt, word_cnt
  );

endinterface

// File: rtl/pair_word_packer_shift_accum.sv
// Pair accumulator: places each accepted pair in its slot and counts filled slots.
// Unfilled slots stay zero because the register is cleared on every emit.
module pair_shift_accum
  import pair_word_packer_pkg::*;
#(
  parameter int  WORD_W    = 8,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int FILL_W    = fill_w(WORD_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PAIR_W-1:0]  pair_in,
  input  logic               accept,
  input  logic               emit,
  output logic [WORD_W-1:0]  full_word,
  output logic [FILL_W-1:0]  fill_cnt
);

  localparam int PAIRS = WORD_W / PAIR_W;

  logic [WORD_W-1:0] shreg_q;
  logic [FILL_W-1:0] fill_q;

  // Slot positions are constants per iteration, so this is a plain mux per slot.
  function automatic logic [WORD_W-1:0] place_pair(
    input logic [WORD_W-1:0] w,
    input logic [PAIR_W-1:0] p,
    input logic [FILL_W-1:0] idx
  );
    logic [WORD_W-1:0] r;
    r = w;
    for (int s = 0; s < PAIRS; s++) begin
      if (idx == FILL_W'(s)) begin
        if (MSB_FIRST) r[WORD_W - PAIR_W*(s+1) +: PAIR_W] = p;
        else           r[PAIR_W*s +: PAIR_W]              = p;
      end
    end
    return r;
  endfunction

  // Includes the pair accepted this cycle so a completing or flushing pair is part of the word.
  always_comb begin
    full_word = shreg_q;
    if (accept) full_word = place_pair(shreg_q, pair_in, fill_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      fill_q  <= '0;
    end else if (emit) begin
      shreg_q <= '0;
      fill_q  <= '0;
    end else if (accept) begin
      shreg_q <= full_word;
      fill_q  <= fill_q + FILL_W'(1);
    end
  end

  assign fill_cnt = fill_q;

endmodule

// File: rtl/pair_word_packer.sv
// Packs 2-bit pairs into WORD_W-bit words and hands them out through a one-entry holding buffer.
// Flush is a level: while the buffer is blocked it must stay asserted until the word is taken.
module pair_word_packer
  import pair_word_packer_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  pair_word_packer_if.slave bus
);

  localparam int PAIRS  = WORD_W / PAIR_W;
  localparam int FILL_W = fill_w(WORD_W);
  localparam logic [FILL_W-1:0] LAST_SLOT = FILL_W'(PAIRS - 1);

  logic [FILL_W-1:0]     fill_cnt;
  logic [WORD_W-1:0]     full_word;
  logic                  last_slot;
  logic                  hold_blocked;
  logic                  pair_ready;
  logic                  accept;
  logic                  complete;
  logic                  flush_eff;
  logic                  load;

  pack_state_e           state_q, state_d;
  logic [WORD_W-1:0]     word_q;
  logic                  word_valid_q;
  logic [WORD_CNT_W-1:0] word_cnt_q;

  pair_shift_accum #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_accum (
    .clk       (clk),
    .reset     (reset),
    .pair_in   (bus.pair_in),
    .accept    (accept),
    .emit      (load),
    .full_word (full_word),
    .fill_cnt  (fill_cnt)
  );

  assign last_slot    = (fill_cnt == LAST_SLOT);
  assign hold_blocked = word_valid_q && !bus.word_ready;

  // Next-state and handshake outputs; a flush only counts if there is something to emit.
  always_comb begin
    pair_ready = !(hold_blocked && (last_slot || bus.flush));
    accept     = bus.pair_valid && pair_ready;
    complete   = accept && last_slot;
    flush_eff  = bus.flush && ((fill_cnt != '0) || accept);
    load       = (complete || flush_eff) && !hold_blocked;

    state_d = EMPTY;
    if (load)
      state_d = EMPTY;
    else if (hold_blocked &&
             ((bus.pair_valid && last_slot) || (bus.flush && (fill_cnt != '0))))
      state_d = STALL;
    else if (accept || (fill_cnt != '0))
      state_d = FILLING;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Holding buffer: a load on the same edge as a consume simply replaces the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q       <= '0;
      word_valid_q <= 1'b0;
      word_cnt_q   <= '0;
    end else if (load) begin
      word_q       <= full_word;
      word_valid_q <= 1'b1;
      word_cnt_q   <= word_cnt_q + WORD_CNT_W'(1);
    end else if (word_valid_q && bus.word_ready) begin
      word_valid_q <= 1'b0;
    end
  end

  // EMPTY is exactly the state with no pairs in the partial word.
  always_ff @(posedge clk) begin
    if (!reset) assert ((state_q == EMPTY) == (fill_cnt == '0));
  end

  assign bus.pair_ready = pair_ready;
  assign bus.word_out   = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.fill_cnt   = fill_cnt;
  assign bus.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_pair_word_packer.sv
// Bench for pair_word_packer: one MSB-first and one LSB-first instance on the same stimulus.
module tb_pair_word_packer;
  import pair_word_packer_pkg::*;

  localparam int WORD_W = 8;
  localparam int PAIRS  = WORD_W / 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pair_word_packer_if #(.WORD_W(WORD_W)) bm ();
  pair_word_packer_if #(.WORD_W(WORD_W)) bl ();

  assign bl.pair_in    = bm.pair_in;
  assign bl.pair_valid = bm.pair_valid;
  assign bl.flush      = bm.flush;
  assign bl.word_ready = bm.word_ready;

  pair_word_packer #(.WORD_W(WORD_W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .bus(bm.slave));
  pair_word_packer #(.WORD_W(WORD_W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .bus(bl.slave));

  int errors = 0;
  int checks = 0;

  // Reference model: partial word as a queue of pairs, plus the held word.
  logic [1:0]  part[$];
  logic        mwv;
  logic [7:0]  mw_m, mw_l;
  logic [15:0] mcnt;

  typedef struct {
    logic [1:0]  p;
    logic        pv, fl, wr;
    logic        e_rdy;
    logic [2:0]  e_fill;
    logic        e_wv;
    logic [7:0]  e_m, e_l;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] build(input bit msb);
    logic [7:0] w = 8'h00;
    for (int i = 0; i < part.size(); i++)
      w = w | (8'(part[i]) << (msb ? (WORD_W - 2 - 2*i) : 2*i));
    return w;
  endfunction

  task automatic drive(input logic [1:0] p, input logic pv, input logic fl,
                       input logic wr, input logic rs);
    bm.pair_in    = p;
    bm.pair_valid = pv;
    bm.flush      = fl;
    bm.word_ready = wr;
    reset         = rs;
  endtask

  task automatic step(input string tag);
    bit exp_rdy, acc, emit;
    #1;
    exp_rdy = !(mwv && !bm.word_ready && (part.size() == PAIRS-1 || bm.flush));
    chk({tag, " rdy_m"}, 32'(bm.pair_ready), 32'(exp_rdy));
    chk({tag, " rdy_l"}, 32'(bl.pair_ready), 32'(exp_rdy));
    @(posedge clk);
    if (reset) begin
      part.delete();
      mwv = 1'b0; mw_m = '0; mw_l = '0; mcnt = '0;
    end else begin
      acc = bm.pair_valid && exp_rdy;
      if (acc) part.push_back(bm.pair_in);
      emit = (part.size() == PAIRS || (bm.flush && part.size() > 0)) &&
             !(mwv && !bm.word_ready);
      if (emit) begin
        mw_m = build(1'b1);
        mw_l = build(1'b0);
        part.delete();
        mwv  = 1'b1;
        mcnt = mcnt + 16'd1;
      end else if (mwv && bm.word_ready) begin
        mwv = 1'b0;
      end
    end
    #1;
    chk({tag, " wv_m"},   32'(bm.word_valid), 32'(mwv));
    chk({tag, " wv_l"},   32'(bl.word_valid), 32'(mwv));
    chk({tag, " word_m"}, 32'(bm.word_out),   32'(mw_m));
    chk({tag, " word_l"}, 32'(bl.word_out),   32'(mw_l));
    chk({tag, " fill_m"}, 32'(bm.fill_cnt),   32'(part.size()));
    chk({tag, " fill_l"}, 32'(bl.fill_cnt),   32'(part.size()));
    chk({tag, " cnt_m"},  32'(bm.word_cnt),   32'(mcnt));
    chk({tag, " cnt_l"},  32'(bl.word_cnt),   32'(mcnt));
  endtask

  initial begin
    //            p     pv    fl    wr    rdy   fill  wv    m      l      cnt
    tbl[0]  = '{2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'h00, 8'h00, 16'd0};
    tbl[1]  = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'h00, 8'h00, 16'd0};
    tbl[2]  = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'h00, 8'h00, 16'd0};
    tbl[3]  = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 8'hC9, 8'h63, 16'd1};
    tbl[4]  = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'hC9, 8'h63, 16'd1};
    tbl[5]  = '{2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'hC9, 8'h63, 16'd1};
    tbl[6]  = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'hC9, 8'h63, 16'd1};
    tbl[7]  = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 8'hD0, 8'h07, 16'd2};
    tbl[8]  = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 8'hD0, 8'h07, 16'd2};
    tbl[9]  = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'hD0, 8'h07, 16'd2};
    tbl[10] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'hD0, 8'h07, 16'd2};
    tbl[11] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'hD0, 8'h07, 16'd2};
    tbl[12] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'hD0, 8'h07, 16'd2};
    tbl[13] = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 8'hA9, 8'h6A, 16'd3};
    tbl[14] = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'hA9, 8'h6A, 16'd3};

    part.delete();
    mwv = 1'b0; mw_m = '0; mw_l = '0; mcnt = '0;

    // Reset and reset-state checks
    drive(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("reset");
    step("reset2");
    drive(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("reset wv",   32'(bm.word_valid), 32'h0);
    chk("reset word", 32'(bm.word_out),   32'h0);
    chk("reset cnt",  32'(bm.word_cnt),   32'h0);

    // Table: back-to-back packing, partial flush, empty flush, flush with completing pair
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].p, tbl[i].pv, tbl[i].fl, tbl[i].wr, 1'b0);
      #1;
      chk($sformatf("tbl%0d rdy", i), 32'(bm.pair_ready), 32'(tbl[i].e_rdy));
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d fill", i), 32'(bm.fill_cnt), 32'(tbl[i].e_fill));
      chk($sformatf("tbl%0d wv", i),   32'(bm.word_valid), 32'(tbl[i].e_wv));
      chk($sformatf("tbl%0d wm", i),   32'(bm.word_out), 32'(tbl[i].e_m));
      chk($sformatf("tbl%0d wl", i),   32'(bl.word_out), 32'(tbl[i].e_l));
      chk($sformatf("tbl%0d cnt", i),  32'(bm.word_cnt), 32'(tbl[i].e_cnt));
    end

    // Held word: next word fills behind it, completing pair stalls
    drive(2'd3, 1'b1, 1'b0, 1'b0, 1'b0); step("t3a");
    drive(2'd0, 1'b1, 1'b0, 1'b0, 1'b0); step("t3b");
    drive(2'd2, 1'b1, 1'b0, 1'b0, 1'b0); step("t3c");
    drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0); step("t3d");
    chk("t3 first word", 32'(bm.word_out), 32'hC9);
    for (int i = 0; i < 3; i++) begin
      drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0); step("t3fill");
    end
    chk("t3 fill3", 32'(bm.fill_cnt), 32'd3);
    drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3 stall rdy", 32'(bm.pair_ready), 32'h0);
      step("t3stall");
      chk("t3 stall word", 32'(bm.word_out), 32'hC9);
      chk("t3 stall fill", 32'(bm.fill_cnt), 32'd3);
    end
    drive(2'd1, 1'b1, 1'b0, 1'b1, 1'b0); step("t3rel");
    chk("t3 word2_m", 32'(bm.word_out),   32'h55);
    chk("t3 word2_l", 32'(bl.word_out),   32'h55);
    chk("t3 wv",      32'(bm.word_valid), 32'h1);
    chk("t3 cnt",     32'(bm.word_cnt),   32'd5);
    drive(2'd0, 1'b0, 1'b0, 1'b1, 1'b0); step("t3idle");

    // Reset mid-word discards the partial word
    for (int i = 0; i < 3; i++) begin
      drive(2'd3, 1'b1, 1'b0, 1'b1, 1'b0); step("t5pre");
    end
    drive(2'd3, 1'b1, 1'b0, 1'b1, 1'b1); step("t5rst");
    chk("t5 word", 32'(bm.word_out),   32'h0);
    chk("t5 wv",   32'(bm.word_valid), 32'h0);
    chk("t5 fill", 32'(bm.fill_cnt),   32'h0);
    chk("t5 cnt",  32'(bm.word_cnt),   32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(2'd2, 1'b1, 1'b0, 1'b1, 1'b0); step("t5post");
    end
    chk("t5 word_m", 32'(bm.word_out), 32'hAA);
    chk("t5 word_l", 32'(bl.word_out), 32'hAA);
    chk("t5 cnt1",   32'(bm.word_cnt), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 99) == 0);
      step("rand");
    end

    // word_cnt wrap: one single-pair flushed word per cycle
    drive(2'd0, 1'b0, 1'b0, 1'b1, 1'b1); step("t6rst");
    while (mcnt != 16'hFFFF) begin
      drive(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b1, 1'b0);
      step("t6run");
    end
    chk("t6 cnt ffff", 32'(bm.word_cnt), 32'hFFFF);
    drive(2'd3, 1'b1, 1'b1, 1'b1, 1'b0); step("t6wrap");
    chk("t6 wrap_m", 32'(bm.word_cnt), 32'h0);
    chk("t6 wrap_l", 32'(bl.word_cnt), 32'h0);
    chk("t6 word_m", 32'(bm.word_out), 32'hC0);
    chk("t6 word_l", 32'(bl.word_out), 32'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
